// File: rtl/ring_buf_wpack_if.sv
// Write-side bundle between the upstream requesters, the packing stage and the ring buffer.
// The slave modport is the packing stage's view; the master modport is the environment's view.
interface ring_buf_wpack_if #(
  parameter int unsigned DATA  = 64,
  parameter int unsigned WRITE = 4
);
  localparam int unsigned WNUM = $clog2(WRITE) + 1;

  logic [WRITE-1:0]           in_v;
  logic [WRITE-1:0][DATA-1:0] in_d;
  logic                       in_ready;
  logic [WRITE-1:0]           out_we;
  logic [WRITE-1:0][DATA-1:0] out_wd;
  logic [WNUM-1:0]            out_num;
  logic                       busy;

  modport slave (
    input  in_v,
    input  in_d,
    output in_ready,
    output out_we,
    output out_wd,
    output out_num,
    input  busy
  );

  modport master (
    output in_v,
    output in_d,
    input  in_ready,
    input  out_we,
    input  out_wd,
    input  out_num,
    output busy
  );
endinterface

// File: rtl/ring_buf_wpack.sv
// Write packing stage in front of the ring buffer: compacts sparse per-lane write requests into
// dense low lanes (order kept) and holds them in one registered stage until the buffer takes them.
// ACT gives the polarity of in_v, out_we and busy (1'b0 = active-low).
// Optional macro RING_BUF_WPACK_STAT_EN adds saturating stat_ent / stat_stall counters.
module ring_buf_wpack #(
  parameter int unsigned DATA  = 64,
  parameter int unsigned WRITE = 4,
  parameter bit          ACT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_,
  ring_buf_wpack_if.slave      bus
`ifdef RING_BUF_WPACK_STAT_EN
  ,
  output logic [31:0]          stat_ent,
  output logic [31:0]          stat_stall
`endif
);

  localparam int unsigned WNUM    = $clog2(WRITE) + 1;
  localparam bit          ENABLE  = ACT;
  localparam bit          DISABLE = !ACT;

  logic                       stage_v_q, stage_v_d;
  logic [WRITE-1:0]           stage_we_q, stage_we_d;
  logic [WRITE-1:0][DATA-1:0] stage_wd_q, stage_wd_d;
  logic [WNUM-1:0]            stage_num_q, stage_num_d;

  logic [WRITE-1:0]           req;
  logic [WNUM-1:0]            rank [WRITE];
  logic [WNUM-1:0]            pop;
  logic [WRITE-1:0]           pack_we;
  logic [WRITE-1:0][DATA-1:0] pack_wd;
  logic                       drain;
  logic                       in_ready;
  logic                       accept;

  // Decode requests to active-high and give each lane its rank (requests below it).
  always_comb begin
    pop = '0;
    for (int i = 0; i < WRITE; i++) begin
      req[i]  = (bus.in_v[i] == ENABLE);
      rank[i] = pop;
      pop     = pop + WNUM'(req[i]);
    end
  end

  // Compaction: output lane k takes the requesting input whose rank is k.
  always_comb begin
    pack_we = {WRITE{DISABLE}};
    pack_wd = '0;
    for (int k = 0; k < WRITE; k++) begin
      for (int i = 0; i < WRITE; i++) begin
        if (req[i] && (rank[i] == WNUM'(k))) begin
          pack_we[k] = ENABLE;
          pack_wd[k] = bus.in_d[i];
        end
      end
    end
  end

  // Handshake: the stage is free when empty or when the buffer takes it this cycle.
  always_comb begin
    drain        = stage_v_q && (bus.busy != ENABLE);
    in_ready     = flush_ && (!stage_v_q || drain);
    accept       = in_ready && (|req);
    bus.in_ready = in_ready;
  end

  // Stage next state; a load in the drain cycle replaces the outgoing bundle.
  always_comb begin
    stage_v_d   = stage_v_q;
    stage_we_d  = stage_we_q;
    stage_wd_d  = stage_wd_q;
    stage_num_d = stage_num_q;
    if (!flush_ || (drain && !accept)) begin
      stage_v_d   = 1'b0;
      stage_we_d  = {WRITE{DISABLE}};
      stage_wd_d  = '0;
      stage_num_d = '0;
    end else if (accept) begin
      stage_v_d   = 1'b1;
      stage_we_d  = pack_we;
      stage_wd_d  = pack_wd;
      stage_num_d = pop;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_v_q   <= 1'b0;
      stage_we_q  <= {WRITE{DISABLE}};
      stage_wd_q  <= '0;
      stage_num_q <= '0;
    end else begin
      stage_v_q   <= stage_v_d;
      stage_we_q  <= stage_we_d;
      stage_wd_q  <= stage_wd_d;
      stage_num_q <= stage_num_d;
    end
  end

  // Cleared stage already reads as all-disabled / zero, so outputs come straight from it.
  assign bus.out_we  = stage_we_q;
  assign bus.out_wd  = stage_wd_q;
  assign bus.out_num = stage_num_q;

`ifdef RING_BUF_WPACK_STAT_EN
  logic [31:0] stat_ent_q, stat_ent_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [32:0] ent_sum;

  // Saturating entry and stall counters; flush clears them like the stage.
  always_comb begin
    ent_sum      = {1'b0, stat_ent_q} + 33'(pop);
    stat_ent_d   = stat_ent_q;
    stat_stall_d = stat_stall_q;
    if (!flush_) begin
      stat_ent_d   = '0;
      stat_stall_d = '0;
    end else begin
      if (accept) begin
        stat_ent_d = ent_sum[32] ? '1 : ent_sum[31:0];
      end
      if (stage_v_q && (bus.busy == ENABLE) && (stat_stall_q != '1)) begin
        stat_stall_d = stat_stall_q + 32'd1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ent_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ent_q   <= stat_ent_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ent   = stat_ent_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_ring_buf_wpack.sv
// Bench for ring_buf_wpack with WRITE=4, DATA=8, active-high polarity.
// Directed steps followed by random traffic against a queue-based model of the staged bundle.
module tb_ring_buf_wpack;
  localparam int unsigned DATA  = 8;
  localparam int unsigned WRITE = 4;
  localparam int unsigned WNUM  = $clog2(WRITE) + 1;

  logic clk = 1'b0;
  logic reset;
  logic flush_;

  always #5 clk = ~clk;

  ring_buf_wpack_if #(.DATA(DATA), .WRITE(WRITE)) bus ();

`ifdef RING_BUF_WPACK_STAT_EN
  logic [31:0] stat_ent;
  logic [31:0] stat_stall;
`endif

  ring_buf_wpack #(
    .DATA (DATA),
    .WRITE(WRITE),
    .ACT  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush_(flush_),
    .bus   (bus)
`ifdef RING_BUF_WPACK_STAT_EN
    ,
    .stat_ent  (stat_ent),
    .stat_stall(stat_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: is a bundle staged, and which data words it holds in output order.
  bit               m_v = 1'b0;
  logic [DATA-1:0]  m_q[$];
  longint unsigned  m_ent   = 0;
  longint unsigned  m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs.
  task automatic step(input string tag, input logic [WRITE-1:0] v,
                      input logic [WRITE*DATA-1:0] d, input bit b, input bit fl, input bit rs,
                      output bit rdy);
    logic [DATA-1:0]       pk[$];
    logic [WRITE-1:0]      exp_we;
    logic [WRITE*DATA-1:0] exp_wd;
    bus.in_v = v;
    bus.in_d = d;
    bus.busy = b;
    flush_   = fl;
    reset    = rs;
    #3;
    rdy = fl && (!m_v || !b);
    chk({tag, ":in_ready"}, 64'(bus.in_ready), 64'(rdy));
    @(posedge clk);
    pk = {};
    for (int i = 0; i < WRITE; i++) if (v[i]) pk.push_back(d[i*DATA +: DATA]);
    if (rs || !fl) begin
      m_ent   = 0;
      m_stall = 0;
    end else begin
      if (rdy && pk.size() > 0) m_ent = m_ent + pk.size();
      if (m_v && b) m_stall++;
      if (m_ent > 64'hFFFF_FFFF) m_ent = 64'hFFFF_FFFF;
      if (m_stall > 64'hFFFF_FFFF) m_stall = 64'hFFFF_FFFF;
    end
    if (rs || !fl) begin
      m_v = 1'b0;
      m_q = {};
    end else if (rdy && pk.size() > 0) begin
      m_v = 1'b1;
      m_q = pk;
    end else if (rdy && m_v) begin
      m_v = 1'b0;
      m_q = {};
    end
    #1;
    exp_we = '0;
    exp_wd = '0;
    for (int k = 0; k < m_q.size(); k++) begin
      exp_we[k]              = 1'b1;
      exp_wd[k*DATA +: DATA] = m_q[k];
    end
    chk({tag, ":out_we"}, 64'(bus.out_we), 64'(exp_we));
    chk({tag, ":out_wd"}, 64'(bus.out_wd), 64'(exp_wd));
    chk({tag, ":out_num"}, 64'(bus.out_num), 64'(m_q.size()));
`ifdef RING_BUF_WPACK_STAT_EN
    chk({tag, ":stat_ent"}, 64'(stat_ent), m_ent);
    chk({tag, ":stat_stall"}, 64'(stat_stall), m_stall);
`endif
  endtask

  initial begin
    bit                    rdy;
    bit                    pending;
    bit                    fl;
    bit                    rs;
    bit                    b;
    logic [WRITE-1:0]      cur_v;
    logic [WRITE*DATA-1:0] cur_d;

    bus.in_v = '0;
    bus.in_d = '0;
    bus.busy = 1'b0;
    flush_   = 1'b1;
    reset    = 1'b1;

    // Reset, then idle.
    step("rst0", 4'b0000, '0, 1'b0, 1'b1, 1'b1, rdy);
    step("rst1", 4'b0000, '0, 1'b0, 1'b1, 1'b1, rdy);
    step("t1_idle", 4'b0000, '0, 1'b0, 1'b1, 1'b0, rdy);
    chk("t1_num", 64'(bus.out_num), 64'd0);
    chk("t1_rdy", 64'(rdy), 64'd1);

    // Sparse pattern compacts to lanes 0..1.
    step("t2", 4'b1010, 32'h3322_1100, 1'b0, 1'b1, 1'b0, rdy);
    chk("t2_we", 64'(bus.out_we), 64'h3);
    chk("t2_wd", 64'(bus.out_wd), 64'h3311);
    chk("t2_num", 64'(bus.out_num), 64'd2);

    // Back-to-back bundles: full identity, then single lane moved down.
    step("t3a", 4'b1111, 32'hDDCC_BBAA, 1'b0, 1'b1, 1'b0, rdy);
    chk("t3a_num", 64'(bus.out_num), 64'd4);
    chk("t3a_wd", 64'(bus.out_wd), 64'hDDCC_BBAA);
    step("t3b", 4'b0100, 32'h00EE_0000, 1'b0, 1'b1, 1'b0, rdy);
    chk("t3b_num", 64'(bus.out_num), 64'd1);
    chk("t3b_wd", 64'(bus.out_wd), 64'hEE);
    step("t3c", 4'b1000, 32'h7700_0000, 1'b0, 1'b1, 1'b0, rdy);
    chk("t3c_top", 64'(bus.out_wd), 64'h77);
    step("drain0", 4'b0000, '0, 1'b0, 1'b1, 1'b0, rdy);

    // Stall with three staged entries and a pending request.
    step("t4_ld", 4'b1101, 32'h4433_2211, 1'b0, 1'b1, 1'b0, rdy);
    for (int c = 0; c < 5; c++) begin
      step("t4_stall", 4'b0011, 32'h0000_9988, 1'b1, 1'b1, 1'b0, rdy);
      chk("t4_we", 64'(bus.out_we), 64'h7);
      chk("t4_wd", 64'(bus.out_wd), 64'h44_3311);
    end
`ifdef RING_BUF_WPACK_STAT_EN
    chk("t4_stat_stall", 64'(stat_stall), 64'd5);
`endif
    step("t4_go", 4'b0011, 32'h0000_9988, 1'b0, 1'b1, 1'b0, rdy);
    chk("t4_go_rdy", 64'(rdy), 64'd1);
    chk("t4_go_wd", 64'(bus.out_wd), 64'h9988);
    step("drain1", 4'b0000, '0, 1'b0, 1'b1, 1'b0, rdy);

    // Flush mid-stall drops both the stage and the presented input.
    step("t5_ld", 4'b0001, 32'h0000_0055, 1'b0, 1'b1, 1'b0, rdy);
    step("t5_stall", 4'b1111, 32'h1234_5678, 1'b1, 1'b1, 1'b0, rdy);
    step("t5_flush", 4'b1111, 32'h1234_5678, 1'b1, 1'b0, 1'b0, rdy);
    chk("t5_we", 64'(bus.out_we), 64'h0);
    chk("t5_num", 64'(bus.out_num), 64'd0);
    step("t5_idle", 4'b0000, '0, 1'b0, 1'b1, 1'b0, rdy);

    // Reset mid-stall; afterwards busy alone must not block the first load.
    step("t6_ld", 4'b0110, 32'h00AB_CD00, 1'b0, 1'b1, 1'b0, rdy);
    step("t6_stall", 4'b1111, 32'hFEDC_BA98, 1'b1, 1'b1, 1'b0, rdy);
    step("t6_rst", 4'b1111, 32'hFEDC_BA98, 1'b1, 1'b1, 1'b1, rdy);
    chk("t6_num", 64'(bus.out_num), 64'd0);
    step("t6_after", 4'b0000, '0, 1'b1, 1'b1, 1'b0, rdy);
    chk("t6_rdy", 64'(rdy), 64'd1);
    step("t6_busy_ld", 4'b0010, 32'h0000_6600, 1'b1, 1'b1, 1'b0, rdy);
    chk("t6_busy_ld_wd", 64'(bus.out_wd), 64'h66);

    // Random traffic; requests are held until accepted.
    pending = 1'b0;
    cur_v   = '0;
    cur_d   = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pending) begin
        cur_v = WRITE'($urandom_range(0, 15));
        cur_d = (WRITE*DATA)'($urandom);
      end
      b  = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 39) != 0);
      rs = ($urandom_range(0, 99) == 0);
      step("rnd", cur_v, cur_d, b, fl, rs, rdy);
      pending = (cur_v != '0) && !rdy && fl && !rs;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
